// File: rtl/eth_ts_fingerprint_tag_if.sv
// Packet and fingerprint streams of the TX timestamp fingerprint tagger.
// The slave modport is the tagger's view; master is the source/sink side.
interface eth_ts_fingerprint_tag_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3,
  parameter int FP_WIDTH    = 8
);
  logic                   asi_pkt_valid;
  logic                   asi_pkt_ready;
  logic [DATA_WIDTH-1:0]  asi_pkt_data;
  logic                   asi_pkt_sop;
  logic                   asi_pkt_eop;
  logic [EMPTY_WIDTH-1:0] asi_pkt_empty;
  logic                   asi_pkt_ts_req;

  logic                   aso_pkt_valid;
  logic                   aso_pkt_ready;
  logic [DATA_WIDTH-1:0]  aso_pkt_data;
  logic                   aso_pkt_sop;
  logic                   aso_pkt_eop;
  logic [EMPTY_WIDTH-1:0] aso_pkt_empty;
  logic                   aso_pkt_ts_req_valid;
  logic [FP_WIDTH-1:0]    aso_pkt_fingerprint;

  logic                   aso_fingerprint_valid;
  logic                   aso_fingerprint_ready;
  logic [FP_WIDTH-1:0]    aso_fingerprint;

  modport slave (
    input  asi_pkt_valid, asi_pkt_data, asi_pkt_sop, asi_pkt_eop,
           asi_pkt_empty, asi_pkt_ts_req, aso_pkt_ready, aso_fingerprint_ready,
    output asi_pkt_ready, aso_pkt_valid, aso_pkt_data, aso_pkt_sop, aso_pkt_eop,
           aso_pkt_empty, aso_pkt_ts_req_valid, aso_pkt_fingerprint,
           aso_fingerprint_valid, aso_fingerprint
  );

  modport master (
    output asi_pkt_valid, asi_pkt_data, asi_pkt_sop, asi_pkt_eop,
           asi_pkt_empty, asi_pkt_ts_req, aso_pkt_ready, aso_fingerprint_ready,
    input  asi_pkt_ready, aso_pkt_valid, aso_pkt_data, aso_pkt_sop, aso_pkt_eop,
           aso_pkt_empty, aso_pkt_ts_req_valid, aso_pkt_fingerprint,
           aso_fingerprint_valid, aso_fingerprint
  );
endinterface

// File: rtl/eth_ts_fingerprint_tag.sv
// Tags timestamp-requesting TX packets with a rolling fingerprint on the SOP
// beat and pushes the same fingerprint to the comparator's FIFO stream.
module eth_ts_fingerprint_tag #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3,
  parameter int FP_WIDTH    = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        csr_ts_enable,
  eth_ts_fingerprint_tag_if.slave     bus,
  output logic                        err_sop,
  output logic [15:0]                 stall_count
);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   ts_req_valid;
    logic [FP_WIDTH-1:0]    fp;
  } beat_t;

  state_e              state_q, state_d;
  beat_t               beat_q, beat_d;
  logic                pkt_vld_q, pkt_vld_d;
  logic                fp_vld_q, fp_vld_d;
  logic [FP_WIDTH-1:0] fp_q, fp_d;
  logic [FP_WIDTH-1:0] fp_cnt_q, fp_cnt_d;
  logic                err_q, err_d;
  logic [15:0]         stall_q, stall_d;

  logic slot_free, in_ready, accept, sop_ok, fwd, drop, ts_hit, in_idle;

  // A new packet may not start while the previous fingerprint is still
  // waiting, which keeps fingerprint order locked to packet order.
  always_comb begin
    in_idle   = (state_q == IDLE);
    slot_free = !pkt_vld_q || bus.aso_pkt_ready;
    in_ready  = reset_n && (in_idle ? (slot_free && !fp_vld_q) : slot_free);
    accept    = bus.asi_pkt_valid && in_ready;
    sop_ok    = in_idle ? bus.asi_pkt_sop : !bus.asi_pkt_sop;
    fwd       = accept && sop_ok;
    drop      = accept && !sop_ok;
    ts_hit    = fwd && in_idle && bus.asi_pkt_ts_req && csr_ts_enable;
  end

  always_comb begin
    state_d = state_q;
    if (fwd) begin
      case (state_q)
        IDLE:    if (!bus.asi_pkt_eop) state_d = BODY;
        BODY:    if (bus.asi_pkt_eop)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pkt_vld_d = pkt_vld_q;
    beat_d    = beat_q;
    if (fwd) begin
      pkt_vld_d           = 1'b1;
      beat_d.data         = bus.asi_pkt_data;
      beat_d.sop          = bus.asi_pkt_sop;
      beat_d.eop          = bus.asi_pkt_eop;
      beat_d.empty        = bus.asi_pkt_empty;
      beat_d.ts_req_valid = ts_hit;
      beat_d.fp           = ts_hit ? fp_cnt_q : '0;
    end else if (bus.aso_pkt_ready) begin
      pkt_vld_d = 1'b0;
    end
  end

  // ts_hit only happens with the fingerprint register empty, so load and
  // pop are mutually exclusive.
  always_comb begin
    fp_vld_d = fp_vld_q;
    fp_d     = fp_q;
    fp_cnt_d = fp_cnt_q;
    if (ts_hit) begin
      fp_vld_d = 1'b1;
      fp_d     = fp_cnt_q;
      fp_cnt_d = fp_cnt_q + 1'b1;
    end else if (fp_vld_q && bus.aso_fingerprint_ready) begin
      fp_vld_d = 1'b0;
      fp_d     = '0;
    end
  end

  always_comb begin
    err_d   = drop;
    stall_d = stall_q;
    if (in_idle && bus.asi_pkt_valid && slot_free && fp_vld_q && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q    <= '0;
      pkt_vld_q <= 1'b0;
      fp_vld_q  <= 1'b0;
      fp_q      <= '0;
      fp_cnt_q  <= '0;
      err_q     <= 1'b0;
      stall_q   <= '0;
    end else begin
      beat_q    <= beat_d;
      pkt_vld_q <= pkt_vld_d;
      fp_vld_q  <= fp_vld_d;
      fp_q      <= fp_d;
      fp_cnt_q  <= fp_cnt_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.asi_pkt_ready         = in_ready;
  assign bus.aso_pkt_valid         = pkt_vld_q;
  assign bus.aso_pkt_data          = beat_q.data;
  assign bus.aso_pkt_sop           = beat_q.sop;
  assign bus.aso_pkt_eop           = beat_q.eop;
  assign bus.aso_pkt_empty         = beat_q.empty;
  assign bus.aso_pkt_ts_req_valid  = beat_q.ts_req_valid;
  assign bus.aso_pkt_fingerprint   = beat_q.fp;
  assign bus.aso_fingerprint_valid = fp_vld_q;
  assign bus.aso_fingerprint       = fp_q;
  assign err_sop                   = err_q;
  assign stall_count               = stall_q;

endmodule
